custom_func_arbiter: RTL and testbench

Shares one LegUp custom-Verilog function instance among NUM_REQ requesters. The instance uses the start/finish/return_val handshake with two 32-bit arguments, for example a custom adder. The block sits between HLS-generated callers and the single accelerator. It arbitrates round-robin, holds the arguments stable for the whole call, and routes the result back to the winning requester over a valid/ready response. A watchdog aborts calls whose finish never arrives.

---
 rtl/custom_func_arbiter.sv | 137 +++++++++++++
 tb/tb_custom_func_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/custom_func_arbiter.sv
// custom_func_arbiter: round-robin sharing of one start/finish custom function among NUM_REQ callers
module custom_func_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_arg_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_arg_j,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_error,
  output logic                      acc_start,
  output logic [DATA_W-1:0]         acc_arg_i,
  output logic [DATA_W-1:0]         acc_arg_j,
  input  logic                      acc_finish,
  input  logic [DATA_W-1:0]         acc_return_val,
  output logic                      busy,
  output logic [ID_W-1:0]           grant_id,
  output logic                      spurious_finish
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t            state_q, state_d;
  logic [ID_W-1:0]   last_q, last_d, grant_q, grant_d, win, idx;
  logic              found;
  logic [DATA_W-1:0] arg_i_q, arg_i_d, arg_j_q, arg_j_d, data_q, data_d;
  logic              err_q, err_d, spur_q, spur_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // first requesting index after the previous owner, wrapping modulo NUM_REQ
  always_comb begin
    found = 1'b0;
    win   = last_q;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((int'(last_q) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    grant_d   = grant_q;
    arg_i_d   = arg_i_q;
    arg_j_d   = arg_j_q;
    data_d    = data_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    spur_d    = spur_q | (acc_finish && (state_q == IDLE || state_q == RESP));
    req_ready = '0;
    rsp_valid = '0;
    acc_start = 1'b0;
    case (state_q)
      IDLE: if (found) begin
        req_ready[win] = 1'b1;
        grant_d        = win;
        arg_i_d        = req_arg_i[int'(win)*DATA_W +: DATA_W];
        arg_j_d        = req_arg_j[int'(win)*DATA_W +: DATA_W];
        state_d        = ISSUE;
      end
      ISSUE: begin
        acc_start = 1'b1;
        cnt_d     = '0;
        if (acc_finish) begin
          data_d  = acc_return_val;
          err_d   = 1'b0;
          state_d = RESP;
        end else state_d = WAIT;
      end
      WAIT: if (acc_finish) begin
        data_d  = acc_return_val;
        err_d   = 1'b0;
        state_d = RESP;
      end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
        data_d  = '0;
        err_d   = 1'b1;
        state_d = RESP;
      end else cnt_d = cnt_q + 1'b1;
      RESP: begin
        rsp_valid[grant_q] = 1'b1;
        if (rsp_ready[grant_q]) begin
          last_d  = grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // handshake strobes are suppressed while reset is asserted
    if (reset) begin
      req_ready = '0;
      rsp_valid = '0;
      acc_start = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= ID_W'(NUM_REQ - 1);
      grant_q <= '0;
      arg_i_q <= '0;
      arg_j_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      spur_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      arg_i_q <= arg_i_d;
      arg_j_q <= arg_j_d;
      data_q  <= data_d;
      err_q   <= err_d;
      spur_q  <= spur_d;
      cnt_q   <= cnt_d;
    end
  end

  assign acc_arg_i       = arg_i_q;
  assign acc_arg_j       = arg_j_q;
  assign rsp_data        = data_q;
  assign rsp_error       = err_q;
  assign busy            = state_q != IDLE;
  assign grant_id        = grant_q;
  assign spurious_finish = spur_q;
endmodule

// File: tb/tb_custom_func_arbiter.sv
// tb_custom_func_arbiter: directed calls checked by a per-cycle call-level model plus literal pins
module tb_custom_func_arbiter;
  localparam int N = 4, W = 32, TO = 10, IW = 2;
  logic clk = 1'b0, reset = 1'b1;
  logic [N-1:0] req_valid = '0, rsp_ready = '1, req_ready, rsp_valid;
  logic [N*W-1:0] req_arg_i = '0, req_arg_j = '0;
  logic [W-1:0] rsp_data, acc_arg_i, acc_arg_j, acc_return_val;
  logic rsp_error, acc_start, acc_finish, busy, spurious_finish;
  logic [IW-1:0] grant_id;
  logic spur_inj = 1'b0;
  int lat = 0, cd = 0, checks = 0, errors = 0;

  custom_func_arbiter #(.NUM_REQ(N), .DATA_W(W), .TIMEOUT(TO), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_arg_i(req_arg_i), .req_arg_j(req_arg_j),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_error(rsp_error), .acc_start(acc_start), .acc_arg_i(acc_arg_i), .acc_arg_j(acc_arg_j),
    .acc_finish(acc_finish), .acc_return_val(acc_return_val), .busy(busy), .grant_id(grant_id),
    .spurious_finish(spurious_finish));

  always #5 clk = ~clk;

  // accelerator: adder finishing lat cycles after start (0 = same cycle, negative = never)
  always_ff @(posedge clk) cd <= reset ? 0 : acc_start ? (lat > 0 ? lat : 0) : (cd > 0 ? cd - 1 : 0);
  assign acc_finish     = spur_inj || (lat == 0 && acc_start) || (lat > 0 && cd == 1);
  assign acc_return_val = spur_inj ? 32'hDEAD_BEEF : acc_arg_i + acc_arg_j;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) if (v[IW'((last + k) % N)]) return (last + k) % N;
    return -1;
  endfunction

  bit armed = 0, m_busy, m_resp, m_err, m_spur;
  int m_age, m_owner, m_last;
  logic [W-1:0] m_ai, m_aj, m_data;

  always @(negedge clk) begin : model
    int w;
    if (reset) begin
      armed = 1; m_busy = 0; m_resp = 0; m_err = 0; m_spur = 0; m_age = 0;
      m_owner = 0; m_last = N - 1; m_ai = 0; m_aj = 0; m_data = 0;
    end else if (armed) begin
      w = m_busy ? -1 : pick(req_valid, m_last);
      chk("m_req_ready", req_ready, w < 0 ? 0 : (1 << w));
      chk("m_acc_start", acc_start, m_busy && !m_resp && m_age == 0);
      chk("m_rsp_valid", rsp_valid, m_resp ? (1 << m_owner) : 0);
      chk("m_busy", busy, m_busy);
      chk("m_grant_id", grant_id, m_owner);
      chk("m_acc_arg_i", acc_arg_i, m_ai);
      chk("m_acc_arg_j", acc_arg_j, m_aj);
      chk("m_rsp_data", rsp_data, m_data);
      chk("m_rsp_error", rsp_error, m_err);
      chk("m_spurious", spurious_finish, m_spur);
      if (!m_busy) begin
        if (acc_finish) m_spur = 1;
        if (w >= 0) begin
          m_owner = w; m_ai = req_arg_i[w*W +: W]; m_aj = req_arg_j[w*W +: W];
          m_busy = 1; m_resp = 0; m_age = 0;
        end
      end else if (!m_resp) begin
        if (acc_finish) begin m_data = m_ai + m_aj; m_err = 0; m_resp = 1; end
        else if (m_age == TO) begin m_data = 0; m_err = 1; m_resp = 1; end
        else m_age++;
      end else begin
        if (acc_finish) m_spur = 1;
        if (rsp_ready[IW'(m_owner)]) begin m_last = m_owner; m_busy = 0; m_resp = 0; end
      end
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic neg(); @(negedge clk); endtask
  task automatic set_req(input int k, input logic [W-1:0] ai, input logic [W-1:0] aj);
    req_arg_i[k*W +: W] = ai;
    req_arg_j[k*W +: W] = aj;
  endtask
  task automatic do_reset();
    tick(); reset = 1; req_valid = '0; rsp_ready = '1; spur_inj = 0;
    tick(); tick(); reset = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int order [6] = '{0, 1, 2, 3, 0, 1};
    int n;
    do_reset();
    neg();
    chk("rst_busy", busy, 0); chk("rst_grant", grant_id, 0);
    chk("rst_data", rsp_data, 0); chk("rst_spur", spurious_finish, 0);
    // single combinational call
    tick(); set_req(0, 5, 7); req_valid = 4'b0001;
    neg(); chk("t1_ready", req_ready, 4'b0001);
    tick(); req_valid = '0;
    neg(); chk("t1_start", acc_start, 1);
    tick(); neg(); chk("t1_rsp_valid", rsp_valid, 4'b0001); chk("t1_data", rsp_data, 12);
    tick(); neg(); chk("t1_idle", busy, 0);
    // round robin with all requesters valid
    do_reset();
    for (int k = 0; k < N; k++) set_req(k, k + 100, k);
    req_valid = '1;
    for (int i = 0; i < 6; i++) begin
      n = 0; neg();
      while (req_ready == 0 && n < 20) begin tick(); neg(); n++; end
      chk("t2_grant", req_ready, 1 << order[i]);
      tick(); n = 0; neg();
      while (rsp_valid == 0 && n < 20) begin tick(); neg(); n++; end
      chk("t2_data", rsp_data, 2 * order[i] + 100);
      tick();
    end
    req_valid = '0;
    // accelerator latency 4, wrapping sum
    do_reset(); lat = 4; set_req(0, 32'hFFFF_FFFF, 1); req_valid = 4'b0001;
    neg(); chk("t3_ready", req_ready, 4'b0001);
    tick(); req_valid = '0; neg(); chk("t3_start", acc_start, 1);
    for (int c = 2; c <= 5; c++) begin
      tick(); neg(); chk("t3_hold_i", acc_arg_i, 32'hFFFF_FFFF); chk("t3_no_rsp", rsp_valid, 0);
    end
    tick(); neg();
    chk("t3_rsp_valid", rsp_valid, 4'b0001); chk("t3_data", rsp_data, 0); chk("t3_hold_j", acc_arg_j, 1);
    tick();
    // timeout, then a working call
    do_reset(); lat = -1; set_req(1, 3, 4); req_valid = 4'b0010;
    neg(); chk("t4_ready", req_ready, 4'b0010);
    tick(); req_valid = '0;
    for (int c = 2; c <= 11; c++) begin tick(); neg(); chk("t4_wait", rsp_valid, 0); end
    tick(); neg();
    chk("t4_rsp_valid", rsp_valid, 4'b0010); chk("t4_err", rsp_error, 1); chk("t4_data", rsp_data, 0);
    tick(); lat = 0; req_valid = 4'b0010; neg(); chk("t4b_ready", req_ready, 4'b0010);
    tick(); req_valid = '0;
    tick(); neg(); chk("t4b_rsp", rsp_valid, 4'b0010); chk("t4b_data", rsp_data, 7); chk("t4b_err", rsp_error, 0);
    tick();
    // backpressure and spurious finish
    do_reset(); rsp_ready = '0; set_req(2, 10, 20); req_valid = 4'b0100;
    neg(); chk("t5_ready", req_ready, 4'b0100);
    tick(); set_req(3, 1, 2); req_valid = 4'b1000;
    tick(); neg(); chk("t5_rsp", rsp_valid, 4'b0100);
    tick(); spur_inj = 1;
    tick(); spur_inj = 0; neg();
    chk("t5_spur", spurious_finish, 1); chk("t5_data", rsp_data, 30); chk("t5_no_grant", req_ready, 0);
    tick(); tick(); neg();
    chk("t5_held", rsp_valid, 4'b0100); chk("t5_no_grant2", req_ready, 0);
    tick(); rsp_ready = '1; neg(); chk("t5_release", rsp_valid, 4'b0100);
    tick(); neg(); chk("t5_next", req_ready, 4'b1000);
    tick(); req_valid = '0;
    tick(); neg(); chk("t5_data3", rsp_data, 3); chk("t5_sticky", spurious_finish, 1);
    tick();
    // reset in WAIT after requester 2 owned the last completed call
    do_reset(); set_req(2, 1, 1); req_valid = 4'b0100;
    neg(); chk("t6_ready2", req_ready, 4'b0100);
    tick(); req_valid = '0;
    tick(); tick(); lat = -1; set_req(1, 9, 9); req_valid = 4'b0010;
    neg(); chk("t6_ready1", req_ready, 4'b0010);
    tick(); req_valid = '0;
    tick(); tick(); neg(); chk("t6_wait", busy, 1);
    tick(); reset = 1;
    tick(); reset = 0; set_req(0, 40, 2); set_req(3, 5, 5); req_valid = 4'b1001;
    neg();
    chk("t6_busy", busy, 0); chk("t6_grant", grant_id, 0); chk("t6_arg", acc_arg_i, 0);
    chk("t6_rsp", rsp_valid, 0); chk("t6_start", acc_start, 0); chk("t6_win0", req_ready, 4'b0001);
    tick(); req_valid = '0; lat = 0;
    tick(); neg(); chk("t6_data", rsp_data, 42);
    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
